// File: rtl/skein_pkg.sv
// ---------------------------------------------------------------------------
// skein_pkg
// Shared definitions for the Skein-1024 UBI sequencer:
//   - FSM state encoding for the two-pass (message, output) sequence
//   - UBI tweak type codes and tweak bit positions
//   - block size limit used to saturate the tweak position field
// No ports (package).
// ---------------------------------------------------------------------------
package skein_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        MSG_START = 3'd1,
        MSG_WAIT  = 3'd2,
        OUT_START = 3'd3,
        OUT_WAIT  = 3'd4,
        DONE      = 3'd5
    } skein_state_t;

    localparam logic [5:0] T_MSG = 6'd48;
    localparam logic [5:0] T_OUT = 6'd63;

    localparam int TWEAK_FINAL   = 127;
    localparam int TWEAK_FIRST   = 126;
    localparam int TWEAK_TYPE_HI = 125;
    localparam int TWEAK_TYPE_LO = 120;

    localparam int BLOCK_MAX_BYTES = 128;

    // The output pass always processes an 8-byte counter block.
    localparam int OUT_POS_BYTES = 8;

endpackage

// File: rtl/skein_tweak_gen.sv
// ---------------------------------------------------------------------------
// skein_tweak_gen
// Combinational UBI tweak builder. Packs the final/first flags, the 6-bit
// block type and the byte position into a 128-bit Threefish tweak; all
// other tweak bits are zero.
// Ports:
//   is_final    in  1        final-block flag (tweak bit 127)
//   is_first    in  1        first-block flag (tweak bit 126)
//   tweak_type  in  6        UBI type code (tweak bits 125:120)
//   pos_bytes   in  LEN_W    byte position (low bits of the tweak)
//   tweak       out TWEAK_W  assembled tweak
// ---------------------------------------------------------------------------
module skein_tweak_gen
    import skein_pkg::*;
#(
    parameter int TWEAK_W = 128,
    parameter int LEN_W   = 8
) (
    input  logic               is_final,
    input  logic               is_first,
    input  logic [5:0]         tweak_type,
    input  logic [LEN_W-1:0]   pos_bytes,
    output logic [TWEAK_W-1:0] tweak
);

    // Start from all-zero so the reserved field between the type code and
    // the position stays cleared, then drop each field into place.
    always_comb begin
        tweak = '0;
        tweak[TWEAK_FINAL] = is_final;
        tweak[TWEAK_FIRST] = is_first;
        tweak[TWEAK_TYPE_HI:TWEAK_TYPE_LO] = tweak_type;
        tweak[LEN_W-1:0] = pos_bytes;
    end

endmodule

// File: rtl/skein_ubi_sequencer.sv
// ---------------------------------------------------------------------------
// skein_ubi_sequencer
// Sequences one Skein-1024 hash of a single-block message (0..128 bytes)
// through a shared Threefish-1024 core: a message UBI pass keyed by the IV
// (key_selector mode 0) followed by an output UBI pass keyed by the chaining
// value (mode 1). Builds tweaks, applies the feed-forward XOR and returns the
// digest over a valid/ready handshake.
//
// Optional feature: define SKEIN_UBI_SEQ_PERF_EN to add hash_count_o, a
// 32-bit wrapping count of consumed digests.
//
// Ports:
//   clk_i         in   1        clock, rising edge
//   rst_i         in   1        synchronous active-high reset
//   msg_valid_i   in   1        message offered
//   msg_ready_o   out  1        sequencer can accept a message
//   msg_i         in   BLOCK_W  zero-padded message block, byte 0 at [7:0]
//   msg_len_i     in   LEN_W    message length in bytes
//   tf_mode_o     out  1        key_selector mode (0 = IV, 1 = chain)
//   tf_chain_o    out  BLOCK_W  chaining value to key_selector
//   tf_tweak_o    out  TWEAK_W  Threefish tweak
//   tf_block_o    out  BLOCK_W  Threefish plaintext
//   tf_start_o    out  1        one-cycle core start pulse
//   tf_done_i     in   1        one-cycle core completion pulse
//   tf_result_i   in   BLOCK_W  core ciphertext, valid with tf_done_i
//   hash_valid_o  out  1        digest available
//   hash_ready_i  in   1        digest consumer ready
//   hash_o        out  BLOCK_W  digest
//   busy_o        out  1        high whenever not IDLE
//   hash_count_o  out  32       consumed-digest count (PERF_EN only)
// ---------------------------------------------------------------------------
module skein_ubi_sequencer
    import skein_pkg::*;
#(
    parameter int BLOCK_W = 1024,
    parameter int TWEAK_W = 128,
    parameter int LEN_W   = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               msg_valid_i,
    output logic               msg_ready_o,
    input  logic [BLOCK_W-1:0] msg_i,
    input  logic [LEN_W-1:0]   msg_len_i,
    output logic               tf_mode_o,
    output logic [BLOCK_W-1:0] tf_chain_o,
    output logic [TWEAK_W-1:0] tf_tweak_o,
    output logic [BLOCK_W-1:0] tf_block_o,
    output logic               tf_start_o,
    input  logic               tf_done_i,
    input  logic [BLOCK_W-1:0] tf_result_i,
    output logic               hash_valid_o,
    input  logic               hash_ready_i,
    output logic [BLOCK_W-1:0] hash_o,
    output logic               busy_o
`ifdef SKEIN_UBI_SEQ_PERF_EN
    ,
    output logic [31:0]        hash_count_o
`endif
);

    localparam logic [LEN_W-1:0] MAX_POS = LEN_W'(BLOCK_MAX_BYTES);
    localparam logic [LEN_W-1:0] OUT_POS = LEN_W'(OUT_POS_BYTES);

    skein_state_t       state;
    logic [BLOCK_W-1:0] msg_q;
    logic [LEN_W-1:0]   msg_pos;
    logic [TWEAK_W-1:0] msg_tweak;
    logic [TWEAK_W-1:0] out_tweak;

    // A single block can never hold more than 128 bytes, so an oversized
    // length is clamped before it reaches the tweak position field.
    always_comb begin
        msg_pos = (msg_len_i > MAX_POS) ? MAX_POS : msg_len_i;
    end

    skein_tweak_gen #(
        .TWEAK_W (TWEAK_W),
        .LEN_W   (LEN_W)
    ) u_msg_tweak (
        .is_final   (1'b1),
        .is_first   (1'b1),
        .tweak_type (T_MSG),
        .pos_bytes  (msg_pos),
        .tweak      (msg_tweak)
    );

    skein_tweak_gen #(
        .TWEAK_W (TWEAK_W),
        .LEN_W   (LEN_W)
    ) u_out_tweak (
        .is_final   (1'b1),
        .is_first   (1'b1),
        .tweak_type (T_OUT),
        .pos_bytes  (OUT_POS),
        .tweak      (out_tweak)
    );

    // Main sequencer. Every core-facing output is loaded on the edge that
    // enters a *_START state, so mode/chain/tweak/block are already valid
    // in the cycle carrying the start pulse and hold until the matching
    // done. The message tweak is built straight from msg_len_i at accept
    // time, which is how the length gets latched. tf_chain_o doubles as the
    // chain register; it is cleared for each new message so the IV pass
    // never sees a stale chain. tf_done_i is only looked at in the two WAIT
    // states, so done pulses after a reset or coincident with a start are
    // dropped.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            msg_ready_o  <= 1'b1;
            busy_o       <= 1'b0;
            msg_q        <= '0;
            tf_mode_o    <= 1'b0;
            tf_chain_o   <= '0;
            tf_tweak_o   <= '0;
            tf_block_o   <= '0;
            tf_start_o   <= 1'b0;
            hash_valid_o <= 1'b0;
            hash_o       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (msg_valid_i && msg_ready_o) begin
                        msg_q       <= msg_i;
                        tf_block_o  <= msg_i;
                        tf_mode_o   <= 1'b0;
                        tf_chain_o  <= '0;
                        tf_tweak_o  <= msg_tweak;
                        tf_start_o  <= 1'b1;
                        msg_ready_o <= 1'b0;
                        busy_o      <= 1'b1;
                        state       <= MSG_START;
                    end
                end
                MSG_START: begin
                    tf_start_o <= 1'b0;
                    state      <= MSG_WAIT;
                end
                MSG_WAIT: begin
                    if (tf_done_i) begin
                        tf_chain_o <= tf_result_i ^ msg_q;
                        tf_mode_o  <= 1'b1;
                        tf_block_o <= '0;
                        tf_tweak_o <= out_tweak;
                        tf_start_o <= 1'b1;
                        state      <= OUT_START;
                    end
                end
                OUT_START: begin
                    tf_start_o <= 1'b0;
                    state      <= OUT_WAIT;
                end
                OUT_WAIT: begin
                    // Output-pass plaintext is the zero counter block, so the
                    // feed-forward XOR leaves the ciphertext unchanged.
                    if (tf_done_i) begin
                        hash_o       <= tf_result_i;
                        hash_valid_o <= 1'b1;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    if (hash_ready_i) begin
                        hash_valid_o <= 1'b0;
                        msg_ready_o  <= 1'b1;
                        busy_o       <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef SKEIN_UBI_SEQ_PERF_EN
    // Counts consumed digests; wraps naturally at 32 bits.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hash_count_o <= '0;
        end else if (hash_valid_o && hash_ready_i) begin
            hash_count_o <= hash_count_o + 32'd1;
        end
    end
`endif

endmodule

// File: doc/skein_ubi_sequencer.md
Name: skein_ubi_sequencer

Overview:
- Sequences one Skein-1024 hash of a single-block message (0..128 bytes) through the shared Threefish-1024 core.
- Runs two UBI passes back to back:
  - message pass: key_selector in message mode, so the IV constant is the key;
  - output pass: key_selector in output mode, so the chaining value is the key.
- Builds the tweaks, applies the feed-forward XOR and returns the 1024-bit digest through a valid/ready handshake.
- Sits between the candidate-message generator and the Threefish core / key_selector pair.

Parameters:
- BLOCK_W, 1024, block, key and digest width.
- TWEAK_W, 128, tweak width.
- LEN_W, 8, message-length field width.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- msg_valid_i  in  1  message offered.
- msg_ready_o  out  1  sequencer can accept a message.
- msg_i  in  1024  message block, zero-padded, byte 0 at [7:0].
- msg_len_i  in  8  message length in bytes.
- tf_mode_o  out  1  key_selector mode: 0 = message (IV), 1 = output (chain).
- tf_chain_o  out  1024  chaining value, driven to key_selector key_i.
- tf_tweak_o  out  128  Threefish tweak.
- tf_block_o  out  1024  Threefish plaintext.
- tf_start_o  out  1  one-cycle start pulse to the Threefish core.
- tf_done_i  in  1  one-cycle completion pulse from the core.
- tf_result_i  in  1024  ciphertext, valid when tf_done_i = 1.
- hash_valid_o  out  1  digest available.
- hash_ready_i  in  1  digest consumer ready.
- hash_o  out  1024  digest.
- busy_o  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst_i = 1 at an edge): state = IDLE.
  - All outputs 0 except msg_ready_o = 1.
  - Chain and message registers cleared.
  - Reset mid-operation aborts immediately; any later tf_done_i is ignored until a new MSG_START.
- IDLE:
  - msg_ready_o = 1.
  - On msg_valid_i & msg_ready_o: latch msg_i and msg_len_i, then go to MSG_START.
- MSG_START:
  - tf_mode_o = 0, tf_block_o = latched message, tf_start_o = 1 for exactly one cycle.
  - tf_tweak_o = {final=1, first=1, type=6'd48, 24'd0, 96'(len)}; upper byte is 0xF0.
  - Next state MSG_WAIT.
- MSG_WAIT:
  - On tf_done_i: chain <= tf_result_i XOR message.
  - Next state OUT_START.
- OUT_START:
  - tf_mode_o = 1, tf_chain_o = chain, tf_block_o = 0 (counter 0).
  - tf_tweak_o = {1, 1, 6'd63, 24'd0, 96'd8}; upper byte is 0xFF.
  - tf_start_o pulses for one cycle. Next state OUT_WAIT.
- OUT_WAIT:
  - On tf_done_i: hash register <= tf_result_i. Feed-forward XOR is with zero, so the result passes straight through.
  - Next state DONE.
- DONE:
  - hash_valid_o = 1 and hash_o stays stable until hash_ready_i.
  - On the handshake go to IDLE; msg_ready_o rises on the following cycle.
- Latency: start of MSG_START to hash_valid_o = 2 + 2·(core latency) cycles.
- tf_mode_o, tf_chain_o, tf_tweak_o and tf_block_o are registered. They stay stable from the start pulse until done.
- tf_done_i outside MSG_WAIT/OUT_WAIT is ignored.
- tf_done_i in the same cycle as tf_start_o is illegal from the core and is ignored.
- msg_len_i > 128 is saturated to 128 in the tweak position field.

Optional Feature:
- Macro: SKEIN_UBI_SEQ_PERF_EN.
- Defined:
  - Adds port hash_count_o out 32, a completed-digest counter.
  - Increments on every hash_valid_o & hash_ready_i handshake.
  - Wraps 0xFFFFFFFF -> 0; reset to 0 by rst_i.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package skein_pkg:
  - state encoding (IDLE, MSG_START, MSG_WAIT, OUT_START, OUT_WAIT, DONE);
  - tweak type constants T_MSG = 6'd48 and T_OUT = 6'd63;
  - tweak bit positions: FINAL = 127, FIRST = 126, TYPE = 125:120;
  - BLOCK_MAX_BYTES = 128.
- Sub-module skein_tweak_gen: combinational tweak builder (type, first, final, position) → 128 bits.

Test Plan:
- Bench uses a stub core with 3-cycle latency and result = block XOR {16{64'hA5A5A5A5A5A5A5A5}}.
- Message pass, msg_len_i = 5:
  - first tf_start_o has tf_mode_o = 0;
  - tf_tweak_o = 128'hF0000000_00000000_00000000_00000005.
- Output pass, same transaction:
  - second start has tf_mode_o = 1 and tf_block_o = 0;
  - tf_tweak_o = 128'hFF000000_00000000_00000000_00000008;
  - tf_chain_o = {16{64'hA5A5...A5}}.
- Back-pressure: hold hash_ready_i = 0 for 10 cycles.
  - hash_valid_o stays 1 and hash_o is stable;
  - msg_ready_o = 0 throughout;
  - after the handshake, msg_ready_o = 1 the next cycle.
- Reset mid-operation: assert rst_i during OUT_WAIT, then return the late tf_done_i.
  - Outputs go to reset values;
  - the late done is ignored and hash_valid_o stays 0;
  - the next message completes normally.
- Boundary lengths: msg_len_i = 0 gives tweak position 0; msg_len_i = 200 gives tweak position 128.
  - With SKEIN_UBI_SEQ_PERF_EN defined, hash_count_o = 2 after both digests are consumed.
